// File: rtl/seq_truth_table.sv
// Reprogrammable N_IN-input truth-table evaluator: 1-stage valid/ready datapath plus a serial rule loader.
// Optional build macro TT_CFG_PARITY_EN appends an even-parity bit to every serial load.
module seq_truth_table #(
    parameter int                     N_IN = 3,
    parameter logic [(2**N_IN)-1:0]   RULE = 8'h92
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_IN-1:0]   in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out,
    input  logic              cfg_start,
    input  logic              cfg_valid,
    input  logic              cfg_bit,
    output logic              cfg_busy,
    output logic              cfg_done,
    output logic              cfg_err
);

    localparam int TT_W = 2**N_IN;
`ifdef TT_CFG_PARITY_EN
    localparam int LOAD_LEN = TT_W + 1;
`else
    localparam int LOAD_LEN = TT_W;
`endif
    localparam int SH_W  = LOAD_LEN - 1;
    localparam int CNT_W = $clog2(TT_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LOAD_LEN - 1);

    typedef enum logic {ACTIVE, LOAD} state_t;

    state_t             state_reg;
    logic [TT_W-1:0]    table_reg;
    logic [SH_W-1:0]    shadow_reg;
    logic [CNT_W-1:0]   bit_cnt_reg;
    logic [TT_W-1:0]    tt_by_idx;
    logic [SH_W:0]      shift_full;
    logic               accept;

    // Rule-number convention: index 0 selects the table MSB, so reverse once here.
    generate
        for (genvar gi = 0; gi < TT_W; gi++) begin : g_rev
            assign tt_by_idx[gi] = table_reg[TT_W-1-gi];
        end
    endgenerate

    assign in_ready   = !out_valid || out_ready;
    assign accept     = in_valid && in_ready;
    assign cfg_busy   = (state_reg == LOAD);
    assign shift_full = {shadow_reg, cfg_bit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out       <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out       <= tt_by_idx[in_data];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifndef TT_CFG_PARITY_EN
    assign cfg_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ACTIVE;
            table_reg   <= RULE;
            shadow_reg  <= '0;
            bit_cnt_reg <= '0;
            cfg_done    <= 1'b0;
`ifdef TT_CFG_PARITY_EN
            cfg_err     <= 1'b0;
`endif
        end else begin
            cfg_done <= 1'b0;
`ifdef TT_CFG_PARITY_EN
            cfg_err  <= 1'b0;
`endif
            case (state_reg)
                ACTIVE: begin
                    if (cfg_start) begin
                        state_reg   <= LOAD;
                        bit_cnt_reg <= '0;
                    end
                end
                LOAD: begin
                    if (cfg_start) begin
                        bit_cnt_reg <= '0;
                    end else if (cfg_valid) begin
                        shadow_reg  <= shift_full[SH_W-1:0];
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        if (bit_cnt_reg == LAST_CNT) begin
                            state_reg   <= ACTIVE;
                            bit_cnt_reg <= '0;
`ifdef TT_CFG_PARITY_EN
                            // Shadow already holds the full rule; the incoming bit is parity.
                            if (^shift_full == 1'b0) begin
                                table_reg <= shadow_reg;
                                cfg_done  <= 1'b1;
                            end else begin
                                cfg_err   <= 1'b1;
                            end
`else
                            table_reg <= shift_full;
                            cfg_done  <= 1'b1;
`endif
                        end
                    end
                end
                default: state_reg <= ACTIVE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_truth_table.sv
// Directed, table-driven bench for seq_truth_table (N_IN=3); honours TT_CFG_PARITY_EN when defined.
module tb_seq_truth_table;

`ifdef TT_CFG_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready, out;
    logic [2:0] in_data;
    logic       cfg_start, cfg_valid, cfg_bit, cfg_busy, cfg_done, cfg_err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0] data;
        logic       exp;
    } vec_t;
    typedef vec_t vec_set_t [8];

    vec_set_t v92, v96, v00, vff;

    seq_truth_table #(.N_IN(3), .RULE(8'h92)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit),
        .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_sweep(input vec_set_t v, input string nm);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = v[i].data;
            tick();
            $display("%s: in_data=%0d out=%0b out_valid=%0b", nm, v[i].data, out, out_valid);
            check({nm, " out_valid"}, 32'(out_valid), 32'd1);
            check({nm, " out"}, 32'(out), 32'(v[i].exp));
        end
        in_valid = 1'b0;
        tick();
        check({nm, " drain"}, 32'(out_valid), 32'd0);
    endtask

    // Start cycle also drives cfg_valid=1: ignored in ACTIVE, discarded on restart in LOAD.
    task automatic load_rule(input logic [7:0] val, input logic par, input logic ok,
                             input logic probe, input logic probe_exp, input string nm);
        int n;
        logic [8:0] bits;
        n    = PAR_EN ? 9 : 8;
        bits = PAR_EN ? {val, par} : {1'b0, val};
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_bit   = 1'b1;
        tick();
        cfg_start = 1'b0;
        check({nm, " busy"}, 32'(cfg_busy), 32'd1);
        for (int k = 0; k < n; k++) begin
            cfg_valid = 1'b1;
            cfg_bit   = bits[n-1-k];
            if (k == n-1 && probe) begin
                in_valid = 1'b1;
                in_data  = 3'd1;
            end
            tick();
            if (k < n-1) check({nm, " early done"}, 32'(cfg_done), 32'd0);
        end
        cfg_valid = 1'b0;
        in_valid  = 1'b0;
        $display("%s: rule=%02h done=%0b err=%0b busy=%0b", nm, val, cfg_done, cfg_err, cfg_busy);
        check({nm, " done"}, 32'(cfg_done), 32'(ok));
        check({nm, " err"}, 32'(cfg_err), 32'(PAR_EN && !ok));
        check({nm, " busy end"}, 32'(cfg_busy), 32'd0);
        if (probe) begin
            check({nm, " commit-edge out"}, 32'(out), 32'(probe_exp));
            check({nm, " commit-edge valid"}, 32'(out_valid), 32'd1);
        end
        tick();
        check({nm, " done pulse"}, 32'(cfg_done), 32'd0);
        check({nm, " err pulse"}, 32'(cfg_err), 32'd0);
    endtask

    initial begin
        // Expected outputs: out = rule[7-in_data].
        v92 = '{'{3'd0,1'b1}, '{3'd1,1'b0}, '{3'd2,1'b0}, '{3'd3,1'b1},
                '{3'd4,1'b0}, '{3'd5,1'b0}, '{3'd6,1'b1}, '{3'd7,1'b0}};
        v96 = '{'{3'd0,1'b1}, '{3'd1,1'b0}, '{3'd2,1'b0}, '{3'd3,1'b1},
                '{3'd4,1'b0}, '{3'd5,1'b1}, '{3'd6,1'b1}, '{3'd7,1'b0}};
        v00 = '{'{3'd0,1'b0}, '{3'd1,1'b0}, '{3'd2,1'b0}, '{3'd3,1'b0},
                '{3'd4,1'b0}, '{3'd5,1'b0}, '{3'd6,1'b0}, '{3'd7,1'b0}};
        vff = '{'{3'd7,1'b1}, '{3'd6,1'b1}, '{3'd5,1'b1}, '{3'd4,1'b1},
                '{3'd3,1'b1}, '{3'd2,1'b1}, '{3'd1,1'b1}, '{3'd0,1'b1}};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        cfg_start = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0;
        tick(); tick();
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out", 32'(out), 32'd0);
        check("reset cfg_busy", 32'(cfg_busy), 32'd0);
        check("reset cfg_done", 32'(cfg_done), 32'd0);
        check("reset cfg_err", 32'(cfg_err), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        run_sweep(v92, "sweep92");

        // Serial bits while ACTIVE must not start anything.
        cfg_valid = 1'b1; cfg_bit = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("active ignore busy", 32'(cfg_busy), 32'd0);
            check("active ignore done", 32'(cfg_done), 32'd0);
        end
        cfg_valid = 1'b0;

        load_rule(8'h96, 1'b0, 1'b1, 1'b0, 1'b0, "load96");
        run_sweep(v96, "sweep96");

        // Backpressure: stall 4 cycles, then one result per cycle.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 3'd3;
        tick();
        check("bp first valid", 32'(out_valid), 32'd1);
        check("bp first out", 32'(out), 32'd1);
        in_data = 3'd1;
        for (int i = 0; i < 4; i++) begin
            check("bp in_ready", 32'(in_ready), 32'd0);
            tick();
            $display("stall cycle %0d: out=%0b out_valid=%0b", i, out, out_valid);
            check("bp held out", 32'(out), 32'd1);
            check("bp held valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        check("bp release in_ready", 32'(in_ready), 32'd1);
        tick();
        check("bp next out", 32'(out), 32'd0);
        check("bp next valid", 32'(out_valid), 32'd1);
        in_data = 3'd3;
        tick();
        check("bp back-to-back out", 32'(out), 32'd1);
        check("bp back-to-back valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        tick();
        check("bp idle valid", 32'(out_valid), 32'd0);
        check("bp idle out holds", 32'(out), 32'd1);

        // Restart after 5 bits, then a full 0x00 load.
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cfg_valid = 1'b1; cfg_bit = 1'b1;
            tick();
        end
        cfg_valid = 1'b0;
        check("partial busy", 32'(cfg_busy), 32'd1);
        check("partial done", 32'(cfg_done), 32'd0);
        load_rule(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, "load00");
        run_sweep(v00, "sweep00");

        // Sample accepted on the commit edge sees the old (all-zero) table.
        load_rule(8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, "loadFF");
        run_sweep(vff, "sweepFF");

        // Reset in the middle of a load.
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cfg_valid = 1'b1; cfg_bit = 1'b1;
            tick();
        end
        cfg_valid = 1'b0;
        check("midload busy", 32'(cfg_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midload reset busy", 32'(cfg_busy), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        run_sweep(v92, "sweep92 after reset");

`ifdef TT_CFG_PARITY_EN
        load_rule(8'h92, 1'b0, 1'b0, 1'b0, 1'b0, "bad parity 92");
        run_sweep(v92, "sweep after bad 92");
        load_rule(8'h96, 1'b1, 1'b0, 1'b0, 1'b0, "bad parity 96");
        run_sweep(v92, "sweep after bad 96");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
